// File: rtl/mux_cfg_pkg.sv
// Shared definitions for the v_line routing configuration controller:
// register word offsets, STATUS bit positions, legal config range and sequencer states.
package mux_cfg_pkg;

    localparam int CFG_W = 4;
    localparam logic [CFG_W-1:0] MAX_CONFIG = 4'd3;

    localparam logic [1:0] OFF_CONFIG = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_TIMING = 2'd2;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_ERR_RANGE = 1;
    localparam int STAT_ERR_BUSY  = 2;
    localparam int STAT_CFG_LSB   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUIESCE = 2'd1,
        ST_SWITCH  = 2'd2,
        ST_SETTLE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/mux_cfg_seq.sv
// Switch sequencer: isolates pads and holds macros in reset around a mux select change,
// with programmable quiesce/settle windows captured when the sequence starts.
module mux_cfg_seq
    import mux_cfg_pkg::*;
#(
    parameter logic [CFG_W-1:0] RESET_CONFIG = 4'd0,
    parameter int               N_MACROS     = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [CFG_W-1:0]    i_target,
    input  logic [7:0]          i_quiesce,
    input  logic [7:0]          i_settle,
    output logic [CFG_W-1:0]    o_configuration,
    output logic                o_pad_oe_en,
    output logic [N_MACROS-1:0] o_macro_rst_n,
    output logic                o_busy
);

    seq_state_t       r_state;
    seq_state_t       w_nextState;
    logic [7:0]       r_cnt;
    logic [7:0]       w_nextCnt;
    logic [7:0]       r_settle;
    logic [CFG_W-1:0] r_configuration;
    logic             r_live;
    logic             w_loadCfg;

    // r_live keeps pads isolated until the first clock after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= ST_IDLE;
            r_cnt           <= 8'd0;
            r_settle        <= 8'd0;
            r_configuration <= RESET_CONFIG;
            r_live          <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            r_live  <= 1'b1;
            if (r_state == ST_IDLE && i_start)
                r_settle <= i_settle;
            if (w_loadCfg)
                r_configuration <= i_target;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_loadCfg   = 1'b0;
        o_pad_oe_en = 1'b0;
        o_busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                o_busy      = 1'b0;
                o_pad_oe_en = r_live;
                if (i_start) begin
                    w_nextState = ST_QUIESCE;
                    w_nextCnt   = (i_quiesce == 8'd0) ? 8'd1 : i_quiesce;
                end
            end
            ST_QUIESCE: begin
                if (r_cnt <= 8'd1) begin
                    w_nextState = ST_SWITCH;
                    w_nextCnt   = 8'd0;
                end else begin
                    w_nextCnt = r_cnt - 8'd1;
                end
            end
            ST_SWITCH: begin
                w_loadCfg = 1'b1;
                if (r_settle == 8'd0) begin
                    w_nextState = ST_IDLE;
                end else begin
                    w_nextState = ST_SETTLE;
                    w_nextCnt   = r_settle;
                end
            end
            ST_SETTLE: begin
                if (r_cnt <= 8'd1) begin
                    w_nextState = ST_IDLE;
                    w_nextCnt   = 8'd0;
                end else begin
                    w_nextCnt = r_cnt - 8'd1;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    assign o_configuration = r_configuration;
    assign o_macro_rst_n   = {N_MACROS{o_pad_oe_en}};

endmodule

// File: rtl/mux_config_ctrl.sv
// Wishbone slave front-end for the v_line routing mux: decodes the 3-word register window,
// holds target/timing/error registers and hands accepted switch requests to mux_cfg_seq.
module mux_config_ctrl
    import mux_cfg_pkg::*;
#(
    parameter logic [31:0]      BASE_ADR     = 32'h3000_0000,
    parameter logic [CFG_W-1:0] RESET_CONFIG = 4'd0,
    parameter int               N_MACROS     = 4,
    parameter logic [7:0]       Q_DEFAULT    = 8'd4,
    parameter logic [7:0]       S_DEFAULT    = 8'd4
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_dat_i,
    input  logic [31:0]         wbs_adr_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic [CFG_W-1:0]    configuration,
    output logic                pad_oe_en,
    output logic [N_MACROS-1:0] macro_rst_n,
    output logic                busy
);

    logic             r_ack;
    logic [31:0]      r_dat;
    logic             r_start;
    logic [CFG_W-1:0] r_target;
    logic [7:0]       r_quiesce;
    logic [7:0]       r_settle;
    logic             r_errRange;
    logic             r_errBusy;

    logic             w_hit;
    logic             w_accept;
    logic             w_write;
    logic [1:0]       w_offset;
    logic [CFG_W-1:0] w_newCfg;
    logic             w_cfgWrite;
    logic             w_statWrite;
    logic             w_timWrite;
    logic             w_pending;
    logic             w_setRange;
    logic             w_setBusy;
    logic             w_clrRange;
    logic             w_clrBusy;
    logic             w_cfgAccept;
    logic [31:0]      w_rdData;
    logic             w_unused;

    // A request is taken only while ack is low, so a held strobe is acked every other cycle.
    assign w_hit       = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:4] == BASE_ADR[31:4]);
    assign w_accept    = w_hit && !r_ack;
    assign w_write     = w_accept && wbs_we_i;
    assign w_offset    = wbs_adr_i[3:2];
    assign w_newCfg    = wbs_dat_i[CFG_W-1:0];

    assign w_cfgWrite  = w_write && (w_offset == OFF_CONFIG) && wbs_sel_i[0];
    assign w_statWrite = w_write && (w_offset == OFF_STATUS) && wbs_sel_i[0];
    assign w_timWrite  = w_write && (w_offset == OFF_TIMING);

    // r_start covers the one cycle before the sequencer reports busy.
    assign w_pending   = busy || r_start;
    assign w_setRange  = w_cfgWrite && (w_newCfg > MAX_CONFIG);
    assign w_setBusy   = w_cfgWrite && !w_setRange && w_pending;
    assign w_cfgAccept = w_cfgWrite && !w_setRange && !w_pending;
    assign w_clrRange  = w_statWrite && wbs_dat_i[STAT_ERR_RANGE];
    assign w_clrBusy   = w_statWrite && wbs_dat_i[STAT_ERR_BUSY];

    assign w_unused    = ^{wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

    always_comb begin
        w_rdData = '0;
        case (w_offset)
            OFF_CONFIG: w_rdData[CFG_W-1:0] = r_target;
            OFF_STATUS: begin
                w_rdData[STAT_BUSY]                  = busy;
                w_rdData[STAT_ERR_RANGE]             = r_errRange;
                w_rdData[STAT_ERR_BUSY]              = r_errBusy;
                w_rdData[STAT_CFG_LSB +: CFG_W]      = configuration;
            end
            OFF_TIMING: w_rdData[15:0] = {r_settle, r_quiesce};
            default:    w_rdData = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_start    <= 1'b0;
            r_target   <= RESET_CONFIG;
            r_quiesce  <= Q_DEFAULT;
            r_settle   <= S_DEFAULT;
            r_errRange <= 1'b0;
            r_errBusy  <= 1'b0;
        end else begin
            r_ack   <= w_accept;
            r_dat   <= (w_accept && !wbs_we_i) ? w_rdData : '0;
            r_start <= w_cfgAccept && (w_newCfg != configuration);
            if (w_cfgAccept)
                r_target <= w_newCfg;
            if (w_timWrite && wbs_sel_i[0])
                r_quiesce <= wbs_dat_i[7:0];
            if (w_timWrite && wbs_sel_i[1])
                r_settle <= wbs_dat_i[15:8];
            // A new error in the same cycle as its clear takes priority.
            r_errRange <= w_setRange || (r_errRange && !w_clrRange);
            r_errBusy  <= w_setBusy  || (r_errBusy  && !w_clrBusy);
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;

    mux_cfg_seq #(
        .RESET_CONFIG (RESET_CONFIG),
        .N_MACROS     (N_MACROS)
    ) u_seq (
        .i_clk           (wb_clk_i),
        .i_rst_n         (wb_rst_ni),
        .i_start         (r_start),
        .i_target        (r_target),
        .i_quiesce       (r_quiesce),
        .i_settle        (r_settle),
        .o_configuration (configuration),
        .o_pad_oe_en     (pad_oe_en),
        .o_macro_rst_n   (macro_rst_n),
        .o_busy          (busy)
    );

endmodule

// File: tb/tb_mux_config_ctrl.sv
// Self-checking bench for mux_config_ctrl: register access over Wishbone, switch sequence
// timing, error flags, reset behaviour and window decode, with expected values queued ahead of the DUT.
module tb_mux_config_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clock = 1'b0;
    logic        resetN;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] datI, adr;
    logic        ack;
    logic [31:0] datO;
    logic [3:0]  cfg;
    logic        padOe;
    logic [3:0]  macroRstN;
    logic        busy;

    int errorCount = 0;
    int checkCount = 0;

    logic [31:0] expQ[$];
    logic [9:0]  seqQ[$];

    always #5 clock = ~clock;

    mux_config_ctrl #(
        .BASE_ADR     (BASE),
        .RESET_CONFIG (4'd0),
        .N_MACROS     (4),
        .Q_DEFAULT    (8'd4),
        .S_DEFAULT    (8'd4)
    ) dut (
        .wb_clk_i      (clock),
        .wb_rst_ni     (resetN),
        .wbs_stb_i     (stb),
        .wbs_cyc_i     (cyc),
        .wbs_we_i      (we),
        .wbs_sel_i     (sel),
        .wbs_dat_i     (datI),
        .wbs_adr_i     (adr),
        .wbs_ack_o     (ack),
        .wbs_dat_o     (datO),
        .configuration (cfg),
        .pad_oe_en     (padOe),
        .macro_rst_n   (macroRstN),
        .busy          (busy)
    );

    // One bus transfer; returns in the ack cycle, lat = 99 when no ack arrives within 8 cycles.
    task automatic wb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rdata, output int lat);
        @(posedge clock); #1;
        cyc = 1'b1; stb = 1'b1; we = wr; adr = a; datI = d; sel = s;
        lat = 99; rdata = '0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clock); #1;
            if (ack === 1'b1) begin
                lat = i;
                rdata = datO;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd, exp;
        int lat;
        logic [31:0] offs[4];
        logic [31:0] exps[4];
        offs = '{32'h4, 32'h0, 32'h8, 32'hC};
        exps = '{32'h0, 32'h0, 32'h0000_0404, 32'h0};
        resetN = 1'b0;
        #12;
        checkCount++;
        if ({padOe, macroRstN, busy, ack} !== 7'b0 || datO !== 32'h0 || cfg !== 4'd0) begin
            errorCount++;
            $display("[TB] FAIL reset_hold: pad=%b macro=%b busy=%b ack=%b dat=%h cfg=%h, expected all zero",
                     padOe, macroRstN, busy, ack, datO, cfg);
        end
        @(posedge clock); #1;
        resetN = 1'b1;
        checkCount++;
        if (padOe !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL release_before_edge: pad=%b, expected 0", padOe);
        end
        @(posedge clock); #1;
        checkCount++;
        if (padOe !== 1'b1 || macroRstN !== 4'hF) begin
            errorCount++;
            $display("[TB] FAIL release_first_edge: pad=%b macro=%b, expected 1 1111", padOe, macroRstN);
        end
        for (int i = 0; i < 4; i++) begin
            expQ.push_back(exps[i]);
            wb_xfer(1'b0, BASE + offs[i], 32'h0, 4'hF, rd, lat);
            exp = expQ.pop_front();
            checkCount++;
            if (rd !== exp || lat != 1) begin
                errorCount++;
                $display("[TB] FAIL reset_read_%0h: got %h lat %0d, expected %h lat 1", offs[i], rd, lat, exp);
            end
        end
    endtask

    task automatic test_switch();
        logic [31:0] rd, exp;
        logic [9:0]  obs, expSeq;
        int lat;
        int idx;
        wb_xfer(1'b1, BASE + 32'h8, 32'h0000_0203, 4'hF, rd, lat);
        for (int i = 0; i <= 7; i++) begin
            logic p, b;
            logic [3:0] c;
            p = (i == 0) || (i == 7);
            b = (i >= 1) && (i <= 6);
            c = (i >= 5) ? 4'd2 : 4'd0;
            seqQ.push_back({{4{p}}, p, b, c});
        end
        wb_xfer(1'b1, BASE, 32'h2, 4'hF, rd, lat);
        checkCount++;
        if (lat != 1) begin
            errorCount++;
            $display("[TB] FAIL switch_write_ack: lat %0d, expected 1", lat);
        end
        idx = 0;
        while (seqQ.size() > 0) begin
            obs = {macroRstN, padOe, busy, cfg};
            expSeq = seqQ.pop_front();
            checkCount++;
            if (obs !== expSeq) begin
                errorCount++;
                $display("[TB] FAIL switch_cycle_%0d: macro/pad/busy/cfg got %b, expected %b", idx, obs, expSeq);
            end
            idx++;
            if (seqQ.size() > 0) begin
                @(posedge clock); #1;
            end
        end
        expQ.push_back(32'h0000_0020);
        wb_xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, rd, lat);
        exp = expQ.pop_front();
        checkCount++;
        if (rd !== exp || lat != 1) begin
            errorCount++;
            $display("[TB] FAIL switch_status: got %h lat %0d, expected %h lat 1", rd, lat, exp);
        end
    endtask

    task automatic test_range();
        logic [31:0] rd, exp;
        int lat;
        logic sawBusy;
        wb_xfer(1'b1, BASE, 32'h5, 4'hF, rd, lat);
        sawBusy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            if (busy !== 1'b0 || padOe !== 1'b1) sawBusy = 1'b1;
        end
        checkCount++;
        if (sawBusy !== 1'b0 || cfg !== 4'd2) begin
            errorCount++;
            $display("[TB] FAIL range_no_sequence: sawBusy=%b cfg=%h, expected 0 2", sawBusy, cfg);
        end
        expQ.push_back(32'h0000_0022);
        expQ.push_back(32'h0000_0020);
        expQ.push_back(32'h0000_0002);
        wb_xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, rd, lat);
        exp = expQ.pop_front();
        checkCount++;
        if (rd !== exp || lat != 1) begin
            errorCount++;
            $display("[TB] FAIL range_status_set: got %h lat %0d, expected %h lat 1", rd, lat, exp);
        end
        wb_xfer(1'b1, BASE + 32'h4, 32'h2, 4'hF, rd, lat);
        wb_xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, rd, lat);
        exp = expQ.pop_front();
        checkCount++;
        if (rd !== exp) begin
            errorCount++;
            $display("[TB] FAIL range_status_clear: got %h, expected %h", rd, exp);
        end
        wb_xfer(1'b0, BASE, 32'h0, 4'hF, rd, lat);
        exp = expQ.pop_front();
        checkCount++;
        if (rd !== exp) begin
            errorCount++;
            $display("[TB] FAIL range_target_kept: got %h, expected %h", rd, exp);
        end
    endtask

    task automatic test_busy_drop();
        logic [31:0] rd, exp;
        int lat;
        int waited;
        wb_xfer(1'b1, BASE, 32'h1, 4'hF, rd, lat);
        wb_xfer(1'b1, BASE, 32'h3, 4'hF, rd, lat);
        checkCount++;
        if (busy !== 1'b1 || lat != 1) begin
            errorCount++;
            $display("[TB] FAIL busy_second_write: busy=%b lat %0d, expected 1 lat 1", busy, lat);
        end
        waited = 0;
        while (busy === 1'b1 && waited < 40) begin
            @(posedge clock); #1;
            waited++;
        end
        checkCount++;
        if (busy !== 1'b0 || cfg !== 4'd1) begin
            errorCount++;
            $display("[TB] FAIL busy_final_config: busy=%b cfg=%h after %0d cycles, expected 0 1", busy, cfg, waited);
        end
        expQ.push_back(32'h0000_0014);
        expQ.push_back(32'h0000_0001);
        expQ.push_back(32'h0000_0010);
        wb_xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, rd, lat);
        exp = expQ.pop_front();
        checkCount++;
        if (rd !== exp) begin
            errorCount++;
            $display("[TB] FAIL busy_status_set: got %h, expected %h", rd, exp);
        end
        wb_xfer(1'b0, BASE, 32'h0, 4'hF, rd, lat);
        exp = expQ.pop_front();
        checkCount++;
        if (rd !== exp) begin
            errorCount++;
            $display("[TB] FAIL busy_target: got %h, expected %h", rd, exp);
        end
        wb_xfer(1'b1, BASE + 32'h4, 32'h4, 4'hF, rd, lat);
        wb_xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, rd, lat);
        exp = expQ.pop_front();
        checkCount++;
        if (rd !== exp) begin
            errorCount++;
            $display("[TB] FAIL busy_status_clear: got %h, expected %h", rd, exp);
        end
    endtask

    task automatic test_zero_timing();
        logic [31:0] rd, exp;
        int lat;
        int busyCnt, lowCnt;
        wb_xfer(1'b1, BASE + 32'h8, 32'h0, 4'hF, rd, lat);
        expQ.push_back(32'h0);
        wb_xfer(1'b0, BASE + 32'h8, 32'h0, 4'hF, rd, lat);
        exp = expQ.pop_front();
        checkCount++;
        if (rd !== exp) begin
            errorCount++;
            $display("[TB] FAIL zero_timing_read: got %h, expected %h", rd, exp);
        end
        wb_xfer(1'b1, BASE, 32'h3, 4'hF, rd, lat);
        busyCnt = 0; lowCnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            if (busy === 1'b1) busyCnt++;
            if (padOe === 1'b0) lowCnt++;
        end
        checkCount++;
        if (busyCnt != 2 || lowCnt != 2 || cfg !== 4'd3) begin
            errorCount++;
            $display("[TB] FAIL zero_timing_seq: busy %0d padLow %0d cfg %h, expected 2 2 3", busyCnt, lowCnt, cfg);
        end
        wb_xfer(1'b1, BASE, 32'h3, 4'hF, rd, lat);
        busyCnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            if (busy === 1'b1) busyCnt++;
        end
        checkCount++;
        if (busyCnt != 0) begin
            errorCount++;
            $display("[TB] FAIL same_value_no_busy: busy %0d cycles, expected 0", busyCnt);
        end
        expQ.push_back(32'h0000_0030);
        wb_xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, rd, lat);
        exp = expQ.pop_front();
        checkCount++;
        if (rd !== exp) begin
            errorCount++;
            $display("[TB] FAIL same_value_status: got %h, expected %h", rd, exp);
        end
    endtask

    task automatic test_sel_lanes();
        logic [31:0] rd, exp;
        int lat;
        wb_xfer(1'b1, BASE + 32'h8, 32'h0000_0A0B, 4'b0001, rd, lat);
        expQ.push_back(32'h0000_000B);
        wb_xfer(1'b0, BASE + 32'h8, 32'h0, 4'hF, rd, lat);
        exp = expQ.pop_front();
        checkCount++;
        if (rd !== exp) begin
            errorCount++;
            $display("[TB] FAIL sel_lane0: got %h, expected %h", rd, exp);
        end
        wb_xfer(1'b1, BASE + 32'h8, 32'h0000_01FF, 4'b0010, rd, lat);
        wb_xfer(1'b1, BASE, 32'h1, 4'b0000, rd, lat);
        expQ.push_back(32'h0000_010B);
        wb_xfer(1'b0, BASE + 32'h8, 32'h0, 4'hF, rd, lat);
        exp = expQ.pop_front();
        checkCount++;
        if (rd !== exp || cfg !== 4'd3 || busy !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL sel_lane1: timing %h cfg %h busy %b, expected %h 3 0", rd, cfg, busy, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, exp;
        int lat;
        wb_xfer(1'b1, BASE + 32'h8, 32'h0000_0801, 4'hF, rd, lat);
        wb_xfer(1'b1, BASE, 32'h2, 4'hF, rd, lat);
        repeat (5) begin
            @(posedge clock); #1;
        end
        checkCount++;
        if (busy !== 1'b1 || cfg !== 4'd2 || padOe !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL mid_settle: busy=%b cfg=%h pad=%b, expected 1 2 0", busy, cfg, padOe);
        end
        #2;
        resetN = 1'b0;
        #1;
        checkCount++;
        if ({padOe, macroRstN, busy, ack} !== 7'b0 || cfg !== 4'd0) begin
            errorCount++;
            $display("[TB] FAIL mid_reset_async: pad=%b macro=%b busy=%b ack=%b cfg=%h, expected zeros",
                     padOe, macroRstN, busy, ack, cfg);
        end
        @(posedge clock); #1;
        resetN = 1'b1;
        @(posedge clock); #1;
        checkCount++;
        if (padOe !== 1'b1 || macroRstN !== 4'hF || busy !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL mid_reset_release: pad=%b macro=%b busy=%b, expected 1 1111 0", padOe, macroRstN, busy);
        end
        expQ.push_back(32'h0000_0404);
        expQ.push_back(32'h0000_0000);
        wb_xfer(1'b0, BASE + 32'h8, 32'h0, 4'hF, rd, lat);
        exp = expQ.pop_front();
        checkCount++;
        if (rd !== exp) begin
            errorCount++;
            $display("[TB] FAIL mid_reset_timing: got %h, expected %h", rd, exp);
        end
        wb_xfer(1'b0, BASE, 32'h0, 4'hF, rd, lat);
        exp = expQ.pop_front();
        checkCount++;
        if (rd !== exp) begin
            errorCount++;
            $display("[TB] FAIL mid_reset_target: got %h, expected %h", rd, exp);
        end
    endtask

    task automatic test_out_of_window();
        logic [31:0] rd;
        int lat;
        wb_xfer(1'b1, BASE + 32'h10, 32'h1, 4'hF, rd, lat);
        checkCount++;
        if (lat != 99 || datO !== 32'h0) begin
            errorCount++;
            $display("[TB] FAIL oow_write_ack: lat %0d dat %h, expected no ack and 0", lat, datO);
        end
        repeat (3) begin
            @(posedge clock); #1;
        end
        checkCount++;
        if (busy !== 1'b0 || cfg !== 4'd0) begin
            errorCount++;
            $display("[TB] FAIL oow_no_effect: busy=%b cfg=%h, expected 0 0", busy, cfg);
        end
        wb_xfer(1'b0, 32'h2FFF_FFF4, 32'h0, 4'hF, rd, lat);
        checkCount++;
        if (lat != 99 || datO !== 32'h0) begin
            errorCount++;
            $display("[TB] FAIL oow_read_ack: lat %0d dat %h, expected no ack and 0", lat, datO);
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] obs, exp;
        @(posedge clock); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h8; sel = 4'hF;
        for (int i = 1; i <= 6; i++)
            expQ.push_back((i % 2 == 1) ? 32'h0000_0404 : 32'h0);
        for (int i = 1; i <= 6; i++) begin
            @(posedge clock); #1;
            obs = {ack, datO};
            exp = {(i % 2 == 1) ? 1'b1 : 1'b0, expQ.pop_front()};
            checkCount++;
            if (obs !== exp) begin
                errorCount++;
                $display("[TB] FAIL held_stb_cycle_%0d: ack/dat got %h, expected %h", i, obs, exp);
            end
        end
        cyc = 1'b0; stb = 1'b0;
    endtask

    initial begin
        resetN = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; datI = 32'h0; adr = 32'h0;
        test_reset();
        test_switch();
        test_range();
        test_busy_drop();
        test_zero_timing();
        test_sel_lanes();
        test_reset_mid();
        test_out_of_window();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
